// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: two bit-reversed words in per beat, one natural-order bin out per beat.
// Latency: first bin is valid the cycle after the last input beat of a frame is accepted.
// Backpressure: in_rdy drops while both banks hold undrained frames; out_rdy=0 freezes out_d/out_idx/out_last.
module fft_out_reorder #(
    parameter int N  = 4,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [DW-1:0] in_d0,
    input  logic [DW-1:0] in_d1,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [DW-1:0] out_d,
    output logic [N-1:0]  out_idx,
    output logic          out_last
);

    localparam int NW = 1 << N;
    localparam logic [N-2:0] WONE = 1;
    localparam logic [N-1:0] RONE = 1;

    logic [DW-1:0] bank [2][NW];

    logic          wbank;
    logic          rbank;
    logic [N-2:0]  wcnt;
    logic [N-1:0]  ridx;
    logic [1:0]    full;
    logic [1:0]    full_nxt;

    logic          wr_acc;
    logic          rd_acc;
    logic          wr_end;
    logic          rd_end;
    logic [N-1:0]  addr0;
    logic [N-1:0]  addr1;

    function automatic logic [N-1:0] bitrev(input logic [N-1:0] a);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i] = a[N-1-i];
        end
        return r;
    endfunction

    assign in_rdy  = !full[wbank];
    assign out_vld = full[rbank];

    assign wr_acc = in_vld && in_rdy;
    assign rd_acc = out_vld && out_rdy;
    assign wr_end = wr_acc && (wcnt == '1);
    assign rd_end = rd_acc && (ridx == '1);

    // Beat k carries output-memory addresses 2k and 2k+1.
    assign addr0 = {wcnt, 1'b0};
    assign addr1 = {wcnt, 1'b1};

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            bank[wbank][bitrev(addr0)] <= in_d0;
            bank[wbank][bitrev(addr1)] <= in_d1;
        end
    end

    // Write completion and read completion always target different banks,
    // so both flag updates can land on the same edge.
    always_comb begin
        full_nxt = full;
        if (wr_end) begin
            full_nxt[wbank] = 1'b1;
        end
        if (rd_end) begin
            full_nxt[rbank] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wbank <= 1'b0;
            rbank <= 1'b0;
            wcnt  <= '0;
            ridx  <= '0;
            full  <= 2'b00;
        end else begin
            full <= full_nxt;
            if (wr_acc) begin
                wcnt <= wcnt + WONE;
                if (wr_end) begin
                    wbank <= ~wbank;
                end
            end
            if (rd_acc) begin
                ridx <= ridx + RONE;
                if (rd_end) begin
                    rbank <= ~rbank;
                end
            end
        end
    end

    assign out_d    = out_vld ? bank[rbank][ridx] : '0;
    assign out_idx  = ridx;
    assign out_last = out_vld && (ridx == '1);

endmodule

// File: tb/tb_fft_out_reorder.sv
// Bench for fft_out_reorder: constant vector table, directed corner sequences, random traffic vs a frame-level model.
module tb_fft_out_reorder;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int NW = 16;
    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          in_vld = 1'b0;
    logic          in_rdy;
    logic [DW-1:0] in_d0 = '0;
    logic [DW-1:0] in_d1 = '0;
    logic          out_vld;
    logic          out_rdy = 1'b0;
    logic [DW-1:0] out_d;
    logic [N-1:0]  out_idx;
    logic          out_last;

    fft_out_reorder #(.N(N), .DW(DW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_d0    (in_d0),
        .in_d1    (in_d1),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_d    (out_d),
        .out_idx  (out_idx),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame-level model: words arrive in memory-address order; bin b lives at address bitrev(b).
    typedef struct {
        logic [DW-1:0] d;
        int            idx;
        bit            last;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] part_q[$];
    int            nfull = 0;

    function automatic int brev(input int a);
        int r = 0;
        for (int i = 0; i < N; i++) begin
            if (((a >> i) & 1) != 0) r |= 1 << (N - 1 - i);
        end
        return r;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        part_q.delete();
        nfull = 0;
    endfunction

    // Sampled outputs of the last step.
    logic          s_rdy, s_vld, s_last;
    logic [DW-1:0] s_d;
    logic [N-1:0]  s_idx;

    task automatic step(input bit v, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input bit r, output bit acc);
        bit   ex_rdy, ex_vld, l;
        exp_t e;
        in_vld  = v;
        in_d0   = d0;
        in_d1   = d1;
        out_rdy = r;
        @(negedge clk);
        s_rdy = in_rdy; s_vld = out_vld; s_d = out_d; s_idx = out_idx; s_last = out_last;
        ex_rdy = (nfull < 2);
        ex_vld = (nfull > 0);
        chk("in_rdy", 64'(in_rdy), 64'(ex_rdy));
        chk("out_vld", 64'(out_vld), 64'(ex_vld));
        if (ex_vld) begin
            chk("out_d", 64'(out_d), 64'(exp_q[0].d));
            chk("out_idx", 64'(out_idx), 64'(exp_q[0].idx));
            chk("out_last", 64'(out_last), 64'(exp_q[0].last));
        end else begin
            chk("out_d_idle", 64'(out_d), 64'(0));
            chk("out_last_idle", 64'(out_last), 64'(0));
        end
        acc = v && ex_rdy;
        if (ex_vld && r) begin
            l = exp_q[0].last;
            void'(exp_q.pop_front());
            if (l) nfull--;
        end
        if (acc) begin
            part_q.push_back(d0);
            part_q.push_back(d1);
            if (part_q.size() == NW) begin
                for (int b = 0; b < NW; b++) begin
                    e.d = part_q[brev(b)];
                    e.idx = b;
                    e.last = (b == NW - 1);
                    exp_q.push_back(e);
                end
                part_q.delete();
                nfull++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Beat generator: data held until accepted.
    int            gk = 0;
    int            gtag = 0;
    bit            grand = 0;
    logic [DW-1:0] pd0, pd1;

    function automatic void new_beat();
        if (grand) begin
            pd0 = $urandom;
            pd1 = $urandom;
        end else begin
            pd0 = DW'(gtag + 2 * gk);
            pd1 = DW'(gtag + 2 * gk + 1);
        end
    endfunction

    function automatic void gen_start(input int tag, input bit rnd);
        gk = 0; gtag = tag; grand = rnd;
        new_beat();
    endfunction

    function automatic void gen_adv(input int next_tag);
        gk++;
        if (gk == NB) begin
            gk = 0;
            gtag = next_tag;
        end
        new_beat();
    endfunction

    typedef struct {
        bit            v;
        logic [DW-1:0] d0, d1;
        bit            r;
        bit            e_rdy, e_vld, e_last;
        logic [DW-1:0] e_d;
        int            e_idx;
    } vec_t;

    vec_t tv[24];
    int   nat[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    task automatic drain_all(input int budget);
        bit a;
        for (int c = 0; c < budget && exp_q.size() > 0; c++) step(0, '0, '0, 1, a);
        chk("drain_done", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        bit   a;
        int   got, gaps, cyc;
        bit   seen, prev_hold;
        logic [DW-1:0] prev_d;
        logic [N-1:0]  prev_idx;

        // Reset state
        @(negedge clk);
        chk("rst_in_rdy", 64'(in_rdy), 64'(1));
        chk("rst_out_vld", 64'(out_vld), 64'(0));
        chk("rst_out_d", 64'(out_d), 64'(0));
        chk("rst_out_idx", 64'(out_idx), 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        @(posedge clk); #1;
        rstn = 1'b1;

        // Single frame from a constant table
        for (int j = 0; j < 24; j++) begin
            tv[j].v = (j < NB);
            tv[j].d0 = DW'(2 * j);
            tv[j].d1 = DW'(2 * j + 1);
            tv[j].r = 1;
            tv[j].e_rdy = 1;
            tv[j].e_vld = (j >= NB);
            tv[j].e_d = (j >= NB) ? DW'(nat[j - NB]) : '0;
            tv[j].e_idx = (j >= NB) ? j - NB : 0;
            tv[j].e_last = (j == 23);
        end
        for (int j = 0; j < 24; j++) begin
            step(tv[j].v, tv[j].d0, tv[j].d1, tv[j].r, a);
            chk("tbl_in_rdy", 64'(s_rdy), 64'(tv[j].e_rdy));
            chk("tbl_out_vld", 64'(s_vld), 64'(tv[j].e_vld));
            chk("tbl_out_d", 64'(s_d), 64'(tv[j].e_d));
            chk("tbl_out_idx", 64'(s_idx), 64'(tv[j].e_idx));
            chk("tbl_out_last", 64'(s_last), 64'(tv[j].e_last));
        end

        // Backpressure: out_rdy toggles, outputs must hold while stalled
        for (int k = 0; k < NB; k++) step(1, DW'(2 * k), DW'(2 * k + 1), 0, a);
        got = 0; prev_hold = 0; prev_d = '0; prev_idx = '0;
        for (int c = 0; c < 64 && got < NW; c++) begin
            step(1'b0, '0, '0, (c % 2) == 0, a);
            if (prev_hold) begin
                chk("bp_hold_d", 64'(s_d), 64'(prev_d));
                chk("bp_hold_idx", 64'(s_idx), 64'(prev_idx));
            end
            if (s_vld && (c % 2) == 0) begin
                chk("bp_seq", 64'(s_d), 64'(nat[got]));
                got++;
            end
            prev_hold = s_vld && (c % 2) != 0;
            prev_d = s_d; prev_idx = s_idx;
        end
        chk("bp_count", 64'(got), 64'(NW));

        // Both banks full: two frames with out_rdy held low
        gen_start(0, 0);
        got = 0;
        for (int c = 0; c < 40 && got < 2 * NB; c++) begin
            step(1, pd0, pd1, 0, a);
            if (a) begin got++; gen_adv(100); end
        end
        chk("full_beats", 64'(got), 64'(2 * NB));
        for (int c = 0; c < 4; c++) begin
            step(1, 32'hdead_beef, 32'hcafe_f00d, 0, a);
            chk("full_in_rdy_low", 64'(s_rdy), 64'(0));
        end
        drain_all(40);

        // Simultaneous final write and final read
        gen_start(200, 0);
        for (int k = 0; k < NB; k++) begin
            step(1, pd0, pd1, 0, a);
            gen_adv(300);
        end
        for (int c = 0; c < NW; c++) begin
            if (c >= NB) begin
                step(1, pd0, pd1, 1, a);
                if (a) gen_adv(0);
            end else begin
                step(0, '0, '0, 1, a);
            end
        end
        step(0, '0, '0, 0, a);
        chk("simul_out_vld", 64'(s_vld), 64'(1));
        chk("simul_out_idx", 64'(s_idx), 64'(0));
        chk("simul_out_d", 64'(s_d), 64'(300));
        chk("simul_in_rdy", 64'(s_rdy), 64'(1));
        drain_all(40);

        // Reset mid-drain and mid-fill
        gen_start(400, 0);
        for (int k = 0; k < NB; k++) begin
            step(1, pd0, pd1, 0, a);
            gen_adv(450);
        end
        for (int k = 0; k < 3; k++) begin
            step(1, pd0, pd1, 1, a);
            gen_adv(450);
        end
        in_vld = 1'b0; out_rdy = 1'b0;
        rstn = 1'b0;
        #1;
        chk("arst_in_rdy", 64'(in_rdy), 64'(1));
        chk("arst_out_vld", 64'(out_vld), 64'(0));
        chk("arst_out_d", 64'(out_d), 64'(0));
        chk("arst_out_idx", 64'(out_idx), 64'(0));
        model_reset();
        @(posedge clk); #1;
        rstn = 1'b1;
        gen_start(500, 0);
        for (int k = 0; k < NB; k++) begin
            step(1, pd0, pd1, 0, a);
            gen_adv(0);
        end
        chk("post_rst_first", 64'(exp_q.size()), 64'(NW));
        drain_all(40);

        // Continuous streaming, 4 frames of random data
        gen_start(0, 1);
        got = 0; gaps = 0; seen = 0; cyc = 0;
        for (int c = 0; c < 200 && got < 4 * NW; c++) begin
            step(cyc < 4 * NB, pd0, pd1, 1, a);
            if (a) begin cyc++; gen_adv(0); end
            if (s_vld) begin got++; seen = 1; end
            else if (seen) gaps++;
        end
        chk("stream_count", 64'(got), 64'(4 * NW));
        chk("stream_gaps", 64'(gaps), 64'(0));

        // Random traffic
        gen_start(0, 1);
        for (int c = 0; c < 1500; c++) begin
            step($urandom_range(0, 3) != 0, pd0, pd1, $urandom_range(0, 2) != 0, a);
            if (a) gen_adv(0);
        end
        for (int c = 0; c < 40 && part_q.size() > 0; c++) begin
            step(1, pd0, pd1, 1, a);
            if (a) gen_adv(0);
        end
        drain_all(80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_out_reorder.md
# fft_out_reorder

Output-side reorder buffer for the memory-based FFT. It sits downstream of the FFT controller's output valid/ready port and accepts two bit-reversed-order result words per beat. It stores each frame of 2^N words in one of two ping-pong banks, then streams the frame out in natural bin order, one word per beat, with its own valid/ready handshake. While one bank drains, the next frame fills the other bank, so back-to-back FFT frames do not stall.

## Interface
- N, 4, log2 of FFT points; one frame is 2^N words, delivered as 2^(N-1) input beats.
- DW, 32, word width (complex sample, {re, im} packed, treated as opaque).
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  reset; one clock, reset is asynchronous and active-low.
- in_vld  input  1  input beat valid (from FFT controller out_vld).
- in_rdy  output  1  buffer can accept a beat (to FFT controller out_rdy).
- in_d0  input  DW  word at FFT output-memory address 2k for beat k.
- in_d1  input  DW  word at FFT output-memory address 2k+1 for beat k.
- out_vld  output  1  out_d holds a valid natural-order bin.
- out_rdy  input  1  downstream accepts out_d.
- out_d  output  DW  bin word; forced to 0 when out_vld=0.
- out_idx  output  N  bin index of out_d (0..2^N-1).
- out_last  output  1  high with the bin at index 2^N-1.

## Operation
- Storage: two banks, each 2^N x DW, held in registers. Write-side state is wbank (1 bit) and wcnt (N-1 bits). Read-side state is rbank (1 bit) and ridx (N bits). There are two full flags, full[1:0].
- Input mapping: beat k carries memory addresses 2k and 2k+1. These hold bins bitrev_N(2k) and bitrev_N(2k+1).
  - On accept, write in_d0 to bank[wbank][bitrev_N(2k)].
  - Write in_d1 to bank[wbank][bitrev_N(2k+1)].
- Write FSM:
  - FILL: a beat is accepted when in_vld && in_rdy, and wcnt increments.
  - On the accept with wcnt = 2^(N-1)-1: set full[wbank], toggle wbank, and wrap wcnt to 0.
  - Write-side condition: in_rdy = !full[wbank].
- Read FSM:
  - IDLE while full[rbank]=0.
  - DRAIN while full[rbank]=1. In DRAIN, out_vld=1, out_d = bank[rbank][ridx], and out_idx = ridx.
  - A word is accepted when out_vld && out_rdy, and ridx increments.
  - On the accept with ridx = 2^N-1: clear full[rbank], toggle rbank, and wrap ridx to 0.
- out_last = out_vld && (ridx == 2^N-1).
- Counters wrap modulo their width. There are no other arithmetic paths.
- Each bank is written only while it is not full and read only while it is full. The two sides never touch the same bank.

## Timing
- Reset values (async, immediate):
  - wbank=0, rbank=0, wcnt=0, ridx=0, full=2'b00.
  - Outputs: in_rdy=1, out_vld=0, out_d=0, out_idx=0, out_last=0.
  - Bank contents are not reset.
- Input latency: the last beat of a frame is accepted at edge t. out_vld rises after edge t (visible in cycle t+1) if rbank was idle. This is one cycle of latency.
- Handshake rules:
  - in_rdy and out_vld are combinational from the flags only. They do not depend on in_vld or out_rdy.
  - When out_rdy=0, out_d, out_idx and out_last are held stable.
- Both banks full: in_rdy=0 until the first read-bank drain completes. in_rdy returns to 1 in the cycle after the final read accept.
- Simultaneous events: a final write accept and a final read accept in the same edge are both honoured. They set and clear different flags, and both bank pointers toggle.
- Back-to-back: with in_vld and out_rdy held high, the throughput is 2^(N-1) input beats and 2^N output beats per frame. The output side is the bottleneck. The input stalls for 2^(N-1) cycles per frame once both banks fill.
- Reset mid-frame: a partial write frame and any undrained frame are discarded. After rstn rises, operation restarts at bank 0 with empty flags.
- in_vld while in_rdy=0: ignored, no state change. The upstream holds its data.

## Test plan
- Single frame, N=4: feed beats k=0..7 with in_d0=2k and in_d1=2k+1, out_rdy=1.
  - Required: out_d = 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 with out_idx 0..15.
  - out_last is high only on 15.
  - out_vld rises one cycle after the beat-7 accept.
- Backpressure: the same frame, with out_rdy toggling 1,0,1,0.
  - Required: out_d and out_idx stay stable during out_rdy=0 cycles.
  - No bin is dropped or duplicated, and the sequence is identical to the single-frame test.
- Both banks full: hold out_rdy=0 and feed two frames (tags +0 and +100).
  - Required: in_rdy=0 after the 16th beat. Further in_vld has no effect.
  - Releasing out_rdy drains frame 0 then frame 1 (100,108,104,...).
  - in_rdy=1 in the cycle after the first drain ends.
- Simultaneous completion: drive the final write beat of frame 1 on the same edge as the final read of frame 0.
  - Required: frame 1 out_vld in the next cycle with out_idx=0.
  - in_rdy stays 1.
- Reset mid-operation: assert rstn low after 3 beats of a frame and mid-drain of the previous one.
  - Required: in_rdy=1, out_vld=0, out_d=0 immediately, without waiting for a clock edge.
  - A subsequent full frame is output correctly from bank 0.
- Continuous streaming: send 4 frames with in_vld=1 and out_rdy=1 throughout.
  - Required: 64 ordered output words.
  - out_vld is continuous after the first frame fills.
